overlap_framer: RTL and testbench

//  Encoder-side counterpart of the decoder overlap-add stage: splits a PCM sample stream into
//  50%-overlapped blocks of 2*HALF_LEN samples for the forward MDCT/windowing stage.

---
 rtl/overlap_framer.sv | 199 +++++++++++++++++++
 tb/tb_overlap_framer.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/overlap_framer.sv
// overlap_framer: splits a PCM stream into 50%-overlapped blocks of 2*HALF_LEN
// samples (previous half + newest half) for the forward MDCT/windowing stage.
// Ports: clk, reset (async, active-low); in_framer_* valid/ready sample input
// with last marker; out_framer_* valid/ready sample output with a 2-bit block
// tag (01 first, 10 normal, 11 flush). Optional OVERLAP_FRAMER_BLKCNT_EN adds
// out_framer_blkCount[15:0], a wrapping count of completed output blocks.
module overlap_framer #(
    parameter int DATA_W   = 65,
    parameter int HALF_LEN = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_framer_pcmSample,
    input  logic              in_framer_last,
    input  logic              in_framer_valid,
    output logic              in_framer_ready,
    output logic [DATA_W-1:0] out_framer_pcmSample,
    output logic [1:0]        out_framer_firstSequence,
    output logic              out_framer_valid,
    input  logic              out_framer_ready
`ifdef OVERLAP_FRAMER_BLKCNT_EN
    ,
    output logic [15:0]       out_framer_blkCount
`endif
);

    localparam int CW = $clog2(2 * HALF_LEN);
    localparam int HW = $clog2(HALF_LEN);
    localparam logic [CW-1:0] H_LAST = CW'(HALF_LEN - 1);
    localparam logic [CW-1:0] B_LAST = CW'(2 * HALF_LEN - 1);
    localparam logic [CW-1:0] H_LEN  = CW'(HALF_LEN);

    typedef enum logic [2:0] {
        FILL, PAD, EMIT_OLD, EMIT_NEW, FLUSH
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]     wcnt, rcnt;
    logic              wsel, first, ended, live;
    logic [DATA_W-1:0] mem [2][HALF_LEN];

    logic          acc, xfer, wr_last, rd_hlast, rd_blast;
    logic [HW-1:0] widx, ridx;

    assign acc      = in_framer_valid && in_framer_ready;
    assign xfer     = out_framer_valid && out_framer_ready;
    assign wr_last  = (wcnt == H_LAST);
    assign rd_hlast = (rcnt == H_LAST);
    assign rd_blast = (rcnt == B_LAST);
    assign widx     = wcnt[HW-1:0];
    assign ridx     = rcnt[HW-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            FILL: begin
                if (acc && wr_last) begin
                    state_nx = EMIT_OLD;
                end else if (acc && in_framer_last) begin
                    state_nx = PAD;
                end
            end
            PAD: begin
                if (wr_last) begin
                    state_nx = EMIT_OLD;
                end
            end
            EMIT_OLD: begin
                if (xfer && rd_hlast) begin
                    state_nx = EMIT_NEW;
                end
            end
            EMIT_NEW: begin
                if (xfer && rd_hlast) begin
                    state_nx = ended ? FLUSH : FILL;
                end
            end
            FLUSH: begin
                if (xfer && rd_blast) begin
                    state_nx = FILL;
                end
            end
            default: state_nx = FILL;
        endcase
    end

    // Outputs decode straight from registered state, so they change only on
    // a clock edge (or immediately on reset) and hold steady while stalled.
    // After the EMIT_NEW toggle, the final data sits in the ~wsel buffer.
    always_comb begin
        in_framer_ready          = live && (state == FILL);
        out_framer_valid         = 1'b0;
        out_framer_pcmSample     = '0;
        out_framer_firstSequence = 2'b00;
        unique case (state)
            EMIT_OLD: begin
                out_framer_valid         = 1'b1;
                out_framer_pcmSample     = mem[~wsel][ridx];
                out_framer_firstSequence = first ? 2'b01 : 2'b10;
            end
            EMIT_NEW: begin
                out_framer_valid         = 1'b1;
                out_framer_pcmSample     = mem[wsel][ridx];
                out_framer_firstSequence = first ? 2'b01 : 2'b10;
            end
            FLUSH: begin
                out_framer_valid         = 1'b1;
                out_framer_firstSequence = 2'b11;
                if (rcnt < H_LEN) begin
                    out_framer_pcmSample = mem[~wsel][ridx];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt  <= '0;
            rcnt  <= '0;
            wsel  <= 1'b0;
            first <= 1'b1;
            ended <= 1'b0;
            live  <= 1'b0;
            for (int i = 0; i < HALF_LEN; i++) begin
                mem[0][i] <= '0;
                mem[1][i] <= '0;
            end
        end else begin
            live <= 1'b1;
            unique case (state)
                FILL: begin
                    if (acc) begin
                        mem[wsel][widx] <= in_framer_pcmSample;
                        wcnt <= wr_last ? '0 : wcnt + 1'b1;
                        if (in_framer_last) begin
                            ended <= 1'b1;
                        end
                    end
                end
                PAD: begin
                    mem[wsel][widx] <= '0;
                    wcnt <= wr_last ? '0 : wcnt + 1'b1;
                end
                EMIT_OLD: begin
                    if (xfer) begin
                        rcnt <= rd_hlast ? '0 : rcnt + 1'b1;
                    end
                end
                EMIT_NEW: begin
                    if (xfer && rd_hlast) begin
                        rcnt  <= '0;
                        wcnt  <= '0;
                        wsel  <= ~wsel;
                        first <= 1'b0;
                    end else if (xfer) begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                FLUSH: begin
                    if (xfer && rd_blast) begin
                        rcnt  <= '0;
                        wcnt  <= '0;
                        first <= 1'b1;
                        ended <= 1'b0;
                        for (int i = 0; i < HALF_LEN; i++) begin
                            mem[0][i] <= '0;
                            mem[1][i] <= '0;
                        end
                    end else if (xfer) begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef OVERLAP_FRAMER_BLKCNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_framer_blkCount <= '0;
        end else if (xfer && ((state == EMIT_NEW && rd_hlast) ||
                              (state == FLUSH && rd_blast))) begin
            out_framer_blkCount <= out_framer_blkCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_overlap_framer.sv
// Testbench for overlap_framer (HALF_LEN=4, DATA_W=65): random and directed
// streams checked against a block-level reference model.
module tb_overlap_framer;

    localparam int DW = 65;
    localparam int H  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_tag;
    logic          out_valid;
    logic          out_ready = 1'b1;
`ifdef OVERLAP_FRAMER_BLKCNT_EN
    logic [15:0]   blk_count;
`endif

    int errors = 0;
    int checks = 0;
    int tmo = 0;
    int stall_bad = 0;
    int stall_seen = 0;

    overlap_framer #(.DATA_W(DW), .HALF_LEN(H)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .in_framer_pcmSample      (in_data),
        .in_framer_last           (in_last),
        .in_framer_valid          (in_valid),
        .in_framer_ready          (in_ready),
        .out_framer_pcmSample     (out_data),
        .out_framer_firstSequence (out_tag),
        .out_framer_valid         (out_valid),
        .out_framer_ready         (out_ready)
`ifdef OVERLAP_FRAMER_BLKCNT_EN
        ,
        .out_framer_blkCount      (blk_count)
`endif
    );

    always #5 clk = ~clk;

    // Collected output transfers (recorded on the negedge preceding the edge
    // that completes them) and a stall-stability watch.
    logic [DW-1:0] got_d[$];
    logic [1:0]    got_t[$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_d;
    logic [1:0]    prev_t;

    always @(negedge clk) begin
        if (reset && prev_stall &&
            (!out_valid || out_data !== prev_d || out_tag !== prev_t)) begin
            stall_bad++;
        end
        if (reset && out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_t.push_back(out_tag);
        end
        prev_stall = reset && out_valid && !out_ready;
        if (prev_stall) stall_seen++;
        prev_d = out_data;
        prev_t = out_tag;
    end

    // Reference model: stream -> halves (zero padded) -> overlapped blocks.
    logic [DW-1:0] m_prev [H];
    bit            m_first;
    logic [DW-1:0] exp_d[$];
    logic [1:0]    exp_t[$];

    task automatic model_reset();
        for (int k = 0; k < H; k++) m_prev[k] = '0;
        m_first = 1;
        exp_d.delete();
        exp_t.delete();
        got_d.delete();
        got_t.delete();
    endtask

    task automatic model_stream(input logic [DW-1:0] s[$], input bit ends);
        int n = s.size();
        int nb = (n + H - 1) / H;
        logic [DW-1:0] half [H];
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < H; k++)
                half[k] = (b * H + k < n) ? s[b * H + k] : '0;
            for (int k = 0; k < H; k++) exp_d.push_back(m_prev[k]);
            for (int k = 0; k < H; k++) exp_d.push_back(half[k]);
            for (int k = 0; k < 2 * H; k++)
                exp_t.push_back(m_first ? 2'b01 : 2'b10);
            m_prev = half;
            m_first = 0;
        end
        if (ends) begin
            for (int k = 0; k < H; k++) exp_d.push_back(m_prev[k]);
            for (int k = 0; k < H; k++) exp_d.push_back('0);
            for (int k = 0; k < 2 * H; k++) exp_t.push_back(2'b11);
            for (int k = 0; k < H; k++) m_prev[k] = '0;
            m_first = 1;
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input bit l);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) tmo++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] s[$], input bit ends);
        for (int i = 0; i < s.size(); i++)
            push(s[i], ends && (i == s.size() - 1));
    endtask

    task automatic wait_out(input int n);
        int t = 0;
        while (got_d.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) tmo++;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        tmo = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 ||
            out_data !== '0 || out_tag !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b data=%0h tag=%b, want 0 0 0 00",
                     in_ready, out_valid, out_data, out_tag);
        end
        apply_reset();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] s[$];
        for (int i = 1; i <= 8; i++) s.push_back(DW'(i));
        model_stream(s, 0);
        for (int i = 0; i < 3; i++) push(s[i], 0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_valid: got %b want 0", out_valid);
        end
        push(s[3], 0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_latency: valid got %b want 1", out_valid);
        end
        for (int i = 4; i < 8; i++) push(s[i], 0);
        wait_out(exp_d.size());
        checks++;
        if (got_d.size() != exp_d.size() || tmo != 0) begin
            errors++;
            $display("FAIL basic_count: got %0d want %0d (timeouts %0d)",
                     got_d.size(), exp_d.size(), tmo);
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_t[i] !== exp_t[i]) begin
                errors++;
                $display("FAIL basic[%0d]: got %0h/%b want %0h/%b",
                         i, got_d[i], got_t[i], exp_d[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_last_pad();
        logic [DW-1:0] s[$];
        apply_reset();
        for (int i = 1; i <= 6; i++) s.push_back(DW'(i));
        model_stream(s, 1);
        send(s, 1);
        wait_out(exp_d.size());
        checks++;
        if (got_d.size() != exp_d.size() || tmo != 0) begin
            errors++;
            $display("FAIL pad_count: got %0d want %0d (timeouts %0d)",
                     got_d.size(), exp_d.size(), tmo);
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_t[i] !== exp_t[i]) begin
                errors++;
                $display("FAIL pad[%0d]: got %0h/%b want %0h/%b",
                         i, got_d[i], got_t[i], exp_d[i], exp_t[i]);
            end
        end
`ifdef OVERLAP_FRAMER_BLKCNT_EN
        checks++;
        if (blk_count !== 16'd3) begin
            errors++;
            $display("FAIL blk_count: got %0d want 3", blk_count);
        end
`endif
    endtask

    task automatic test_single();
        logic [DW-1:0] s[$];
        got_d.delete();
        got_t.delete();
        exp_d.delete();
        exp_t.delete();
        s.push_back(DW'(7));
        model_stream(s, 1);
        send(s, 1);
        wait_out(exp_d.size());
        checks++;
        if (got_d.size() != exp_d.size() || tmo != 0) begin
            errors++;
            $display("FAIL single_count: got %0d want %0d", got_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_t[i] !== exp_t[i]) begin
                errors++;
                $display("FAIL single[%0d]: got %0h/%b want %0h/%b",
                         i, got_d[i], got_t[i], exp_d[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_random_ready();
        logic [DW-1:0] s[$];
        bit done = 0;
        got_d.delete();
        got_t.delete();
        exp_d.delete();
        exp_t.delete();
        stall_bad = 0;
        stall_seen = 0;
        for (int i = 0; i < 40; i++)
            s.push_back(DW'({$urandom, $urandom, $urandom}));
        model_stream(s, 1);
        fork
            begin
                send(s, 1);
                wait_out(exp_d.size());
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom % 2) == 1;
                end
            end
        join
        out_ready = 1'b1;
        checks++;
        if (got_d.size() != exp_d.size() || tmo != 0) begin
            errors++;
            $display("FAIL rand_count: got %0d want %0d (timeouts %0d)",
                     got_d.size(), exp_d.size(), tmo);
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_t[i] !== exp_t[i]) begin
                errors++;
                $display("FAIL rand[%0d]: got %0h/%b want %0h/%b",
                         i, got_d[i], got_t[i], exp_d[i], exp_t[i]);
            end
        end
        checks++;
        if (stall_bad !== 0 || stall_seen == 0) begin
            errors++;
            $display("FAIL stall_stable: unstable=%0d stalls=%0d, want 0 and >0",
                     stall_bad, stall_seen);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] s[$];
        int t = 0;
        apply_reset();
        for (int i = 1; i <= 4; i++) s.push_back(DW'(i));
        send(s, 0);
        while (got_d.size() < H + 2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== 2'b00) begin
            errors++;
            $display("FAIL async_reset: vld=%b data=%0h tag=%b want 0 0 00",
                     out_valid, out_data, out_tag);
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        tmo = 0;
        s.delete();
        for (int i = 9; i <= 12; i++) s.push_back(DW'(i));
        model_stream(s, 0);
        send(s, 0);
        wait_out(exp_d.size());
        checks++;
        if (got_d.size() != exp_d.size() || tmo != 0) begin
            errors++;
            $display("FAIL restart_count: got %0d want %0d", got_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_t[i] !== exp_t[i]) begin
                errors++;
                $display("FAIL restart[%0d]: got %0h/%b want %0h/%b",
                         i, got_d[i], got_t[i], exp_d[i], exp_t[i]);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_last_pad();
        test_single();
        test_random_ready();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
